// File: rtl/cache_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// cache_mem_arbiter_if
//
// Purpose: bundles the I-cache refill port, the D-cache refill/write-back port
// and the shared external memory port used by cache_mem_arbiter.
//
// Modports:
//   master - the arbiter's view: it accepts cache requests, issues memory
//            requests and write beats, and returns refill beats / write acks.
//   slave  - the surrounding environment's view (caches plus memory model).
//
// Signal groups:
//   i_req_* / i_rsp_*        I-cache line refill request and refill beats
//   d_req_* / d_wdata_*      D-cache line request and write-back beats
//   d_rsp_*                  D-cache refill beats or write acknowledge
//   mem_req_* / mem_wdata_*  memory request and write beats
//   mem_rsp_*                memory read beats or write acknowledge
// ----------------------------------------------------------------------------
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              i_req_valid;
    logic              i_req_ready;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_rsp_valid;
    logic [DATA_W-1:0] i_rsp_data;
    logic              i_rsp_last;

    logic              d_req_valid;
    logic              d_req_ready;
    logic [ADDR_W-1:0] d_req_addr;
    logic              d_req_we;
    logic              d_wdata_valid;
    logic              d_wdata_ready;
    logic [DATA_W-1:0] d_wdata;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rsp_data;
    logic              d_rsp_last;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_we;
    logic              mem_wdata_valid;
    logic              mem_wdata_ready;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wdata_last;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;
    logic              mem_rsp_last;

    modport master (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_last,
        input  d_req_valid, d_req_addr, d_req_we, d_wdata_valid, d_wdata,
        output d_req_ready, d_wdata_ready, d_rsp_valid, d_rsp_data, d_rsp_last,
        output mem_req_valid, mem_req_addr, mem_req_we,
        output mem_wdata_valid, mem_wdata, mem_wdata_last,
        input  mem_req_ready, mem_wdata_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_last
    );

    modport slave (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_last,
        output d_req_valid, d_req_addr, d_req_we, d_wdata_valid, d_wdata,
        input  d_req_ready, d_wdata_ready, d_rsp_valid, d_rsp_data, d_rsp_last,
        input  mem_req_valid, mem_req_addr, mem_req_we,
        input  mem_wdata_valid, mem_wdata, mem_wdata_last,
        output mem_req_ready, mem_wdata_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_last
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// ----------------------------------------------------------------------------
// cache_mem_arbiter
//
// Purpose: shares one external memory port between the I-cache refill path
// (reads only) and the D-cache path (line refills and dirty-line write-backs).
// One line transaction is granted at a time and run to completion:
// request handshake, burst data, then response / write acknowledge.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset (0 = reset)
//   bus    cache_mem_arbiter_if.master - cache and memory handshakes
//   busy   1 while a transaction is in progress (state != IDLE)
//   owner  side owning the current transaction: 0 = I, 1 = D
//
// Configuration macro:
//   ARB_RR_EN  when defined, ties in IDLE alternate between the two sides
//              (first tie after reset goes to I). When undefined, the D side
//              always wins a tie.
// ----------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_mem_arbiter_if.master  bus,
    output logic                 busy,
    output logic                 owner
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    // Byte offset inside one line; these address bits are forced to zero.
    localparam int OFF_W = $clog2(BURST_LEN * DATA_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_WR,
        S_WACK
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
`ifdef ARB_RR_EN
    logic              last_owner_q, last_owner_d;
`endif

    logic              pick_d;
    logic              i_req_ready, d_req_ready;
    logic              i_rsp_valid, i_rsp_last;
    logic [DATA_W-1:0] i_rsp_data;
    logic              d_rsp_valid, d_rsp_last, d_wdata_ready;
    logic [DATA_W-1:0] d_rsp_data;
    logic              mem_req_valid, mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_wdata_valid, mem_wdata_last;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        owner_d         = owner_q;
        addr_d          = addr_q;
        we_d            = we_q;
`ifdef ARB_RR_EN
        last_owner_d    = last_owner_q;
`endif
        pick_d          = 1'b0;
        i_req_ready     = 1'b0;
        d_req_ready     = 1'b0;
        i_rsp_valid     = 1'b0;
        i_rsp_data      = '0;
        i_rsp_last      = 1'b0;
        d_rsp_valid     = 1'b0;
        d_rsp_data      = '0;
        d_rsp_last      = 1'b0;
        d_wdata_ready   = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_addr    = '0;
        mem_req_we      = 1'b0;
        mem_wdata_valid = 1'b0;
        mem_wdata       = '0;
        mem_wdata_last  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_req_valid && bus.d_req_valid) begin
`ifdef ARB_RR_EN
                    // The side that did not win the previous grant goes first.
                    pick_d = ~last_owner_q;
`else
                    pick_d = 1'b1;
`endif
                end else begin
                    pick_d = bus.d_req_valid;
                end
                // Readies are gated by rst so every output is 0 in reset.
                if (rst && (bus.i_req_valid || bus.d_req_valid)) begin
                    d_req_ready = pick_d;
                    i_req_ready = ~pick_d;
                    owner_d     = pick_d;
                    addr_d      = (pick_d ? bus.d_req_addr : bus.i_req_addr) & LINE_MASK;
                    we_d        = pick_d & bus.d_req_we;
`ifdef ARB_RR_EN
                    last_owner_d = pick_d;
`endif
                    state_d     = S_REQ;
                end
            end

            S_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = addr_q;
                mem_req_we    = we_q;
                if (bus.mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = we_q ? S_WR : S_RD;
                end
            end

            S_RD: begin
                if (owner_q) begin
                    d_rsp_valid = bus.mem_rsp_valid;
                    d_rsp_data  = bus.mem_rsp_data;
                    d_rsp_last  = bus.mem_rsp_last;
                end else begin
                    i_rsp_valid = bus.mem_rsp_valid;
                    i_rsp_data  = bus.mem_rsp_data;
                    i_rsp_last  = bus.mem_rsp_last;
                end
                if (bus.mem_rsp_valid && bus.mem_rsp_last) begin
                    state_d = S_IDLE;
                end
            end

            S_WR: begin
                mem_wdata_valid = bus.d_wdata_valid;
                d_wdata_ready   = bus.mem_wdata_ready;
                mem_wdata       = bus.d_wdata;
                mem_wdata_last  = (cnt_q == LAST_BEAT);
                if (bus.d_wdata_valid && bus.mem_wdata_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_WACK;
                    end
                end
            end

            S_WACK: begin
                if (bus.mem_rsp_valid) begin
                    d_rsp_valid = 1'b1;
                    d_rsp_last  = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
`ifdef ARB_RR_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
`ifdef ARB_RR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    // Address and write flag are only observed while in REQ, so they need no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        we_q   <= we_d;
    end

    assign bus.i_req_ready     = i_req_ready;
    assign bus.i_rsp_valid     = i_rsp_valid;
    assign bus.i_rsp_data      = i_rsp_data;
    assign bus.i_rsp_last      = i_rsp_last;
    assign bus.d_req_ready     = d_req_ready;
    assign bus.d_wdata_ready   = d_wdata_ready;
    assign bus.d_rsp_valid     = d_rsp_valid;
    assign bus.d_rsp_data      = d_rsp_data;
    assign bus.d_rsp_last      = d_rsp_last;
    assign bus.mem_req_valid   = mem_req_valid;
    assign bus.mem_req_addr    = mem_req_addr;
    assign bus.mem_req_we      = mem_req_we;
    assign bus.mem_wdata_valid = mem_wdata_valid;
    assign bus.mem_wdata       = mem_wdata;
    assign bus.mem_wdata_last  = mem_wdata_last;

    assign busy  = (state_q != S_IDLE);
    assign owner = owner_q;

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single external memory port between the I-cache refill path (read-only) and the D-cache path (line refill reads and dirty-line write-backs).
- Sits below the fetch and load/store caches.
- Grants one line transaction at a time and runs it to completion: request, burst data, response.
- Default policy is fixed priority with D-side first, so loads and stores are not stalled behind instruction prefetch.

Parameters:
ADDR_W, 64, address width.
DATA_W, 64, beat width in bits.
BURST_LEN, 4, beats per cache line (power of 2, ≥2).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low (0 = reset)
i_req_valid  in  1  I-cache refill request
i_req_ready  out  1  request accepted this cycle
i_req_addr  in  ADDR_W  line address
i_rsp_valid  out  1  refill beat valid
i_rsp_data  out  DATA_W  refill beat
i_rsp_last  out  1  final refill beat
d_req_valid  in  1  D-cache request
d_req_ready  out  1  request accepted this cycle
d_req_addr  in  ADDR_W  line address
d_req_we  in  1  1 = write-back, 0 = refill
d_wdata_valid  in  1  write-back beat valid
d_wdata_ready  out  1  write-back beat accepted
d_wdata  in  DATA_W  write-back beat
d_rsp_valid  out  1  refill beat, or write acknowledge
d_rsp_data  out  DATA_W  refill beat (0 on write acknowledge)
d_rsp_last  out  1  final beat, or write acknowledge
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  line address, low log2(BURST_LEN*DATA_W/8) bits forced to 0
mem_req_we  out  1  write flag
mem_wdata_valid  out  1  write beat valid
mem_wdata_ready  in  1  memory accepts write beat
mem_wdata  out  DATA_W  write beat
mem_wdata_last  out  1  final write beat
mem_rsp_valid  in  1  read beat, or write acknowledge
mem_rsp_data  in  DATA_W  read beat
mem_rsp_last  in  1  last read beat; always 1 on write acknowledge
busy  out  1  state != IDLE
owner  out  1  0 = I, 1 = D; valid while busy

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, beat counter = 0, owner = 0.
  - All outputs 0.
  - Any in-flight memory transaction is abandoned (the memory side shares rst).
- States: IDLE, REQ, RD, WR, WACK.
- IDLE:
  - Both requests valid: D wins. Only one valid: that one wins.
  - Winner's *_req_ready = 1 combinationally in the same cycle.
  - On that cycle, latch addr, we and owner; go to REQ.
  - The loser's ready stays 0.
  - I-side requests are always reads (we = 0).
- REQ:
  - mem_req_valid = 1 with latched addr/we, held stable until mem_req_ready.
  - On the handshake: we = 0 → RD; we = 1 → WR with counter cleared.
- RD:
  - Combinational pass-through: owner's rsp_valid = mem_rsp_valid, rsp_data = mem_rsp_data, rsp_last = mem_rsp_last.
  - Non-owner rsp_valid = 0.
  - mem_rsp_valid with mem_rsp_last → IDLE.
  - No backpressure on responses; the caches always accept refill beats.
- WR:
  - mem_wdata_valid = d_wdata_valid, d_wdata_ready = mem_wdata_ready, mem_wdata = d_wdata.
  - mem_wdata_last = (counter == BURST_LEN-1).
  - Counter increments on each beat handshake.
  - Handshake on the last beat → WACK.
- WACK:
  - On mem_rsp_valid: d_rsp_valid = d_rsp_last = 1 for one cycle, d_rsp_data = 0; → IDLE.
- Minimum one IDLE cycle between transactions; no back-to-back grants.
- mem_rsp_valid in IDLE, REQ or WR is ignored; nothing is forwarded.
- d_wdata_valid outside WR is not acknowledged (d_wdata_ready = 0).
- Requester must hold valid/addr until its ready is seen. A requester deasserting valid in IDLE before grant is legal and causes no grant.

Optional Feature:
- Macro ARB_RR_EN.
- Defined:
  - A last_owner register (reset = D) updates on each grant.
  - When both request in IDLE, the side not granted last wins: the first tie after reset goes to I, then sides alternate.
  - A single requester is always granted.
- Undefined: fixed D priority; no last_owner register.

Test Plan:
- I refill alone: i_req addr 0x8000_0010, mem_req_ready after 2 cycles, 4 read beats 0x11..0x44 → mem_req_addr = 0x8000_0000, we = 0; i_rsp beats 0x11..0x44; i_rsp_last on the 4th; busy drops the next cycle.
- Simultaneous i_req and d_req (read) → d_req_ready = 1, owner = 1, i_req_ready = 0. After the D burst, an IDLE cycle, then I is granted.
- D write-back 0x1000, beats A, B, C, D with d_wdata_valid gaps and mem_wdata_ready stalls → exactly 4 mem beats in order; mem_wdata_last only on D; a single d_rsp_valid pulse after the acknowledge.
- Reset asserted mid-RD after 2 of 4 beats → outputs 0 and busy = 0 immediately (asynchronous). After release, a new I request is granted normally.
- Stray mem_rsp_valid in IDLE → no i_rsp_valid or d_rsp_valid; state unchanged.
- ARB_RR_EN: three consecutive ties after reset → grants I, D, I. Without the macro: D, D, D.
